// File: rtl/cell_renderer_pkg.sv
// Shared cell-state encodings, colour constants and sync levels
// for the Life board display path.
package cell_renderer_pkg;

  typedef enum logic [1:0] {
    DEAD       = 2'b00,
    JUST_ALIVE = 2'b01,
    JUST_DEAD  = 2'b10,
    ALIVE      = 2'b11
  } cell_state_t;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_RED    = 12'hF00;
  localparam logic [11:0] COL_YELLOW = 12'hFF0;
  localparam logic [11:0] COL_GREEN  = 12'h0F0;
  localparam logic [11:0] COL_WHITE  = 12'hFFF;
  localparam logic [11:0] COL_GRID   = 12'h444;

  localparam logic SYNC_IDLE = 1'b1;

endpackage

// File: rtl/cell_color_lut.sv
// Cell state to 4:4:4 colour map, shared with the editor display.
module cell_color_lut
  import cell_renderer_pkg::*;
(
  input  cell_state_t state,
  output logic [11:0] color
);

  always_comb begin
    color = COL_BLACK;
    unique case (state)
      DEAD:       color = COL_BLACK;
      JUST_DEAD:  color = COL_RED;
      JUST_ALIVE: color = COL_YELLOW;
      ALIVE:      color = COL_GREEN;
    endcase
  end

endmodule

// File: rtl/cell_renderer.sv
// Two-stage VGA renderer for the Life cell grid with cursor,
// grid lines and a frame counter driving the cursor blink.
module cell_renderer
  import cell_renderer_pkg::*;
#(
  parameter int COORD_W    = 11,
  parameter int CELL_SHIFT = 7,
  parameter int COL_BITS   = 2,
  parameter int ROW_BITS   = 2,
  parameter int BLINK_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic                         de_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         grid_en,
  input  logic                         cursor_en,
  input  logic [COL_BITS-1:0]          cursor_col,
  input  logic [ROW_BITS-1:0]          cursor_row,
  output logic                         rd_en,
  output logic [ROW_BITS+COL_BITS-1:0] rd_addr,
  input  logic [1:0]                   rd_data,
  output logic [11:0]                  rgb,
  output logic                         de_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic [BLINK_W-1:0]           frame_cnt
);

  localparam logic [COORD_W-1:0] COL_LIM =
    COORD_W'(1) << COL_BITS;
  localparam logic [COORD_W-1:0] ROW_LIM =
    COORD_W'(1) << ROW_BITS;

  logic [COL_BITS-1:0]   col;
  logic [ROW_BITS-1:0]   row;
  logic [CELL_SHIFT-1:0] x_lo;
  logic [CELL_SHIFT-1:0] y_lo;
  logic                  in_range;
  logic                  is_edge;
  logic                  cursor_hit;

  assign col  = x[CELL_SHIFT +: COL_BITS];
  assign row  = y[CELL_SHIFT +: ROW_BITS];
  assign x_lo = x[CELL_SHIFT-1:0];
  assign y_lo = y[CELL_SHIFT-1:0];

  // Full upper-bit compare: any bit above the field is off-board
  assign in_range = ((x >> CELL_SHIFT) < COL_LIM) &&
                    ((y >> CELL_SHIFT) < ROW_LIM);
  assign is_edge  = (&x_lo) | ~(|x_lo) |
                    (&y_lo) | ~(|y_lo);
  assign cursor_hit = (col == cursor_col) &&
                      (row == cursor_row);

  logic s1_de;
  logic s1_in_range;
  logic s1_edge;
  logic s1_cursor;
  logic s1_grid;
  logic s1_hsync;
  logic s1_vsync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      s1_de       <= 1'b0;
      s1_in_range <= 1'b0;
      s1_edge     <= 1'b0;
      s1_cursor   <= 1'b0;
      s1_grid     <= 1'b0;
      s1_hsync    <= SYNC_IDLE;
      s1_vsync    <= SYNC_IDLE;
    end else begin
      rd_en       <= de_in & in_range;
      rd_addr     <= {row, col};
      s1_de       <= de_in;
      s1_in_range <= in_range;
      s1_edge     <= is_edge;
      s1_cursor   <= cursor_en & cursor_hit;
      s1_grid     <= grid_en;
      s1_hsync    <= hsync_in;
      s1_vsync    <= vsync_in;
    end
  end

  logic        vs_prev;
  logic        frame_start;
  logic        blink_on;

  assign frame_start = vs_prev & ~vsync_in;
  assign blink_on    = ~frame_cnt[BLINK_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev   <= SYNC_IDLE;
      frame_cnt <= '0;
    end else begin
      vs_prev <= vsync_in;
      if (frame_start)
        frame_cnt <= frame_cnt + BLINK_W'(1);
    end
  end

  logic        s1_valid;
  cell_state_t state;
  logic [11:0] state_color;
  logic [11:0] pix_color;

  // RAM data is only meaningful behind a real read
  assign s1_valid = s1_de & s1_in_range;
  assign state    = s1_valid ? cell_state_t'(rd_data) : DEAD;

  cell_color_lut u_lut (
    .state (state),
    .color (state_color)
  );

  always_comb begin
    pix_color = COL_BLACK;
    if (!s1_valid)
      pix_color = COL_BLACK;
    else if (s1_cursor && s1_edge && blink_on)
      pix_color = COL_WHITE;
    else if (state != DEAD)
      pix_color = state_color;
    else if (s1_grid && s1_edge)
      pix_color = COL_GRID;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= COL_BLACK;
      de_out    <= 1'b0;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      rgb       <= pix_color;
      de_out    <= s1_de;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
    end
  end

endmodule

// File: doc/cell_renderer.md
Name: cell_renderer

Overview:
- Pipelined VGA cell-grid renderer for the Life board, generalised in grid size and cell size.
- Takes pixel coordinates from the VGA timing generator and reads each cell's 2-bit {was_alive, is_alive} state from the board RAM (1-cycle read latency).
- Outputs registered RGB plus delay-matched sync and data-enable signals.
- Adds a blinking cursor overlay, optional grid lines, and frame counting.

Parameters:
- COORD_W, 11, width of the x/y pixel coordinates.
- CELL_SHIFT, 7, log2 of the cell edge length in pixels (128 px cells).
- COL_BITS, 2, log2 of the number of grid columns.
- ROW_BITS, 2, log2 of the number of grid rows.
- BLINK_W, 5, frame-counter width; the cursor toggles every 2^(BLINK_W-1) frames.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- x  in  COORD_W  current pixel column.
- y  in  COORD_W  current pixel row.
- de_in  in  1  active-video flag for x/y.
- hsync_in  in  1  horizontal sync, active-low.
- vsync_in  in  1  vertical sync, active-low.
- grid_en  in  1  draw cell borders for dead cells.
- cursor_en  in  1  enable the cursor overlay.
- cursor_col  in  COL_BITS  cursor cell column.
- cursor_row  in  ROW_BITS  cursor cell row.
- rd_en  out  1  board RAM read strobe.
- rd_addr  out  ROW_BITS+COL_BITS  board RAM address, {row,col}.
- rd_data  in  2  {was_alive,is_alive}, valid the cycle after rd_en.
- rgb  out  12  4:4:4 pixel colour.
- de_out  out  1  delayed de_in.
- hsync_out  out  1  delayed hsync_in.
- vsync_out  out  1  delayed vsync_in.
- frame_cnt  out  BLINK_W  frames since reset, wrapping.

Behaviour:
- Reset (asynchronous, active-high):
  - rgb=0, de_out=0, rd_en=0, rd_addr=0, frame_cnt=0.
  - hsync_out=1, vsync_out=1 (idle level).
  - All pipeline registers are cleared and the internal vsync history is set to 1.
- Stage 0 (combinational on inputs, registered into S1 at the clock edge):
  - col = x[CELL_SHIFT +: COL_BITS], row = y[CELL_SHIFT +: ROW_BITS].
  - in_range = (x >> CELL_SHIFT) < 2^COL_BITS and (y >> CELL_SHIFT) < 2^ROW_BITS. Compare the full upper bits; any set bit above the col/row field means out of range.
  - edge = low CELL_SHIFT bits of x all-0 or all-1, or the same for y.
  - rd_en = de_in & in_range. rd_addr = {row,col}, registered (RAM sees them in S1).
  - S1 captures de, in_range, edge, cursor_hit, hsync, vsync.
  - cursor_hit = (col==cursor_col) & (row==cursor_row).
- Stage 2: colour is computed from rd_data and the S1 flags, then registered into rgb, de_out, hsync_out and vsync_out.
- Latency: exactly 2 clocks from x/y/syncs to rgb/syncs. Syncs and de take the same delay, with no skew.
- Colour, in priority order:
  1. ~de or ~in_range: 12'h000. The cursor and grid are suppressed.
  2. cursor_en & cursor_hit & edge & blink_on: 12'hFFF.
  3. State colour: 00 → 12'h000, 10 (just dead) → 12'hF00, 01 (just born) → 12'hFF0, 11 (alive) → 12'h0F0. A non-zero state wins over rule 4.
  4. State 00 & grid_en & edge: 12'h444.
- Frame counter:
  - A frame start is a falling edge of vsync_in, detected against the registered previous value.
  - frame_cnt increments by 1 on each frame start and wraps from 2^BLINK_W-1 to 0.
  - blink_on = ~frame_cnt[BLINK_W-1], so the cursor is visible immediately after reset.
- rd_data is don't-care on cycles that follow rd_en=0; the design must not propagate X from it (mask with the S1 de&in_range flag).
- grid_en, cursor_en, cursor_col and cursor_row are sampled per pixel with no frame synchronisation. A change mid-frame takes effect 2 clocks later.
- Reset mid-line: outputs go to their reset values immediately. The pipeline refills from the next clock after reset deasserts; the first valid rgb appears 2 clocks later.

Decomposition:
- Shared package:
  - cell-state encodings DEAD=2'b00, JUST_ALIVE=2'b01, JUST_DEAD=2'b10, ALIVE=2'b11;
  - colour constants COL_BLACK, COL_RED, COL_YELLOW, COL_GREEN, COL_WHITE, COL_GRID;
  - the sync idle level.
- One sub-module, cell_color_lut: a combinational map from state to 12-bit colour, reused by the future editor display.
- The pipeline, frame counter and priority mux stay in cell_renderer.

Test Plan:
- Reset: assert rst mid-line → rgb=0, hsync_out=vsync_out=1, frame_cnt=0 asynchronously. After release, the first valid pixel appears 2 clocks after the first de_in.
- Latency and addressing: x=130, y=260, de=1, RAM returns 2'b11 → rd_addr={2'd2,2'd1}=4'b1001. rgb=12'h0F0 exactly 2 clocks later, with hsync_out matching hsync_in delayed by 2.
- Colour map: sweep rd_data over 00/10/01/11 at an interior pixel (x=64, y=64) → rgb 000/F00/FF0/0F0.
- Range and blanking:
  - x=512, y=10 (col field overflows) → rd_en=0, rgb=0, even with cursor_en=1 and the cursor at (0,0).
  - de_in=0 → rgb=0.
- Grid and cursor:
  - grid_en=1, state 00, x=128 → rgb=12'h444.
  - Same pixel with state 01 → FF0.
  - Cursor at (1,0), cursor_en=1, x=128, y=0 → FFF.
  - x=129, y=5 → FF0, because that pixel is not an edge.
- Blink and wrap: drive 16 vsync falling edges → frame_cnt=16, blink_on=0, and the cursor pixel shows the state colour. After 32 edges → frame_cnt wraps to 0 and the cursor is visible again.
